tagged_mem_responder: RTL and testbench

Memory-side responder for the processor's tagged split-transaction memory port, i.e. the device that the dcache/icache arbiter issues MEM_LOAD/MEM_STORE commands to. It accepts at most one command per cycle and hands back a transaction tag in the same cycle. Each load completes a fixed LATENCY cycles later with a one-cycle data/data_tag pulse. It backs the pipeline in simulation and acts as the synthesizable stand-in for the off-chip memory controller.

---
 rtl/tagged_mem_responder.sv | 123 ++++++++++++
 tb/tb_tagged_mem_responder.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/tagged_mem_responder.sv
// Tagged split-transaction memory responder: allocates the lowest free tag, returns load data later.
// Latency: transaction tag is combinational in the command cycle; load data appears LATENCY cycles after acceptance.
// Backpressure: when every tag is busy the command is refused with tag 0 and has no side effects.
module tagged_mem_responder #(
    parameter int NUM_TAGS  = 15,
    parameter int LATENCY   = 4,
    parameter int MEM_DEPTH = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  proc2mem_command,
    input  logic [31:0] proc2mem_addr,
    input  logic [63:0] proc2mem_data,
    output logic [3:0]  mem2proc_transaction_tag,
    output logic [63:0] mem2proc_data,
    output logic [3:0]  mem2proc_data_tag,
    output logic [3:0]  outstanding_count
);

    localparam logic [1:0] MEM_NONE  = 2'd0;
    localparam logic [1:0] MEM_LOAD  = 2'd1;
    localparam logic [1:0] MEM_STORE = 2'd2;

    localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    typedef struct packed {
        logic        vld;
        logic        is_load;
        logic [3:0]  tag;
        logic [63:0] data;
    } pipe_t;

    // Bit 0 is never used; tags live in bits 1..NUM_TAGS.
    logic [15:0] busy_q, busy_d;
    logic [3:0]  cnt_q, cnt_d;
    pipe_t       pipe_q [LATENCY];
    pipe_t       head;
    pipe_t       entry_d;

    logic [63:0] mem [MEM_DEPTH];

    logic [28:0]   blk;
    logic [AW-1:0] idx;
    logic          in_range;
    logic [63:0]   rd_data;
    logic [3:0]    free_tag;
    logic          free_found;
    logic          accept;
    logic          unused_addr_bits;

    assign unused_addr_bits = ^proc2mem_addr[2:0];

    assign blk      = proc2mem_addr[31:3];
    assign idx      = blk[AW-1:0];
    assign in_range = ({3'b000, blk} < 32'(MEM_DEPTH));
    assign rd_data  = in_range ? mem[idx] : 64'd0;
    assign head     = pipe_q[LATENCY-1];

    // Pick the lowest-numbered free tag from the currently registered busy set.
    always_comb begin
        free_tag   = 4'd0;
        free_found = 1'b0;
        for (int i = NUM_TAGS; i >= 1; i--) begin
            if (!busy_q[i]) begin
                free_tag   = 4'(i);
                free_found = 1'b1;
            end
        end
    end

    // A command is taken only outside reset and only when a tag is available.
    assign accept = (proc2mem_command != MEM_NONE) && free_found && !reset;
    assign mem2proc_transaction_tag = accept ? free_tag : 4'd0;

    // Next busy set: the head frees its tag, a new acceptance claims one (never the same tag).
    always_comb begin
        busy_d = busy_q;
        if (head.vld) begin
            busy_d[head.tag] = 1'b0;
        end
        if (accept) begin
            busy_d[free_tag] = 1'b1;
        end
        cnt_d = 4'($countones(busy_d));

        entry_d         = '0;
        entry_d.vld     = accept;
        entry_d.is_load = (proc2mem_command == MEM_LOAD);
        entry_d.tag     = free_tag;
        entry_d.data    = rd_data;
    end

    // Tag bookkeeping and the fixed-latency completion shift register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_q <= '0;
            cnt_q  <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            busy_q    <= busy_d;
            cnt_q     <= cnt_d;
            pipe_q[0] <= entry_d;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    // Storage write; reads above see the old contents at the same edge.
    always_ff @(posedge clock) begin
        if (accept && (proc2mem_command == MEM_STORE) && in_range) begin
            mem[idx] <= proc2mem_data;
        end
    end

    // Stores reach the head silently; only loads produce a data pulse.
    assign mem2proc_data_tag = (head.vld && head.is_load) ? head.tag  : 4'd0;
    assign mem2proc_data     = (head.vld && head.is_load) ? head.data : 64'd0;
    assign outstanding_count = cnt_q;

endmodule

// File: tb/tb_tagged_mem_responder.sv
module tb_tagged_mem_responder;

    localparam logic [1:0] N = 2'd0;
    localparam logic [1:0] L = 2'd1;
    localparam logic [1:0] S = 2'd2;
    localparam logic [63:0] D = 64'hDEADBEEF_CAFEF00D;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  cmd   = N;
    logic [31:0] addr  = '0;
    logic [63:0] wdat  = '0;
    logic [3:0]  ttag, dtag, cnt;
    logic [63:0] rdat;

    logic [1:0]  cmd2  = N;
    logic [31:0] addr2 = '0;
    logic [63:0] wdat2 = '0;
    logic [3:0]  ttag2, dtag2, cnt2;
    logic [63:0] rdat2;

    int checks   = 0;
    int failures = 0;

    tagged_mem_responder dut (
        .clock(clock), .reset(reset),
        .proc2mem_command(cmd), .proc2mem_addr(addr), .proc2mem_data(wdat),
        .mem2proc_transaction_tag(ttag), .mem2proc_data(rdat),
        .mem2proc_data_tag(dtag), .outstanding_count(cnt)
    );

    tagged_mem_responder #(.NUM_TAGS(2)) dut2 (
        .clock(clock), .reset(reset),
        .proc2mem_command(cmd2), .proc2mem_addr(addr2), .proc2mem_data(wdat2),
        .mem2proc_transaction_tag(ttag2), .mem2proc_data(rdat2),
        .mem2proc_data_tag(dtag2), .outstanding_count(cnt2)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  cmd;
        logic [31:0] addr;
        logic [63:0] wdat;
        logic [3:0]  ttag;
        logic [3:0]  dtag;
        logic [63:0] rdat;
        logic [3:0]  cnt;
    } vec_t;

    vec_t tbl [31];

    function automatic vec_t row(logic [1:0] c, logic [31:0] a, logic [63:0] w,
                                 logic [3:0] tt, logic [3:0] dt, logic [63:0] rd, logic [3:0] oc);
        vec_t v;
        v.cmd = c; v.addr = a; v.wdat = w; v.ttag = tt; v.dtag = dt; v.rdat = rd; v.cnt = oc;
        return v;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs on the first instance, then let outputs settle.
    task automatic drive(logic [1:0] c, logic [31:0] a, logic [63:0] w);
        @(negedge clock);
        cmd = c; addr = a; wdat = w;
        #1;
    endtask

    task automatic drive2(logic [1:0] c);
        @(negedge clock);
        cmd2 = c; addr2 = 32'h8;
        #1;
    endtask

    initial begin
        // Cycle-by-cycle stream: single load, store->load, load->store,
        // back-to-back loads incl. out-of-range, out-of-range store.
        tbl[0]  = row(L, 32'h8,     0, 1, 0, 0, 0);
        tbl[1]  = row(N, 0,         0, 0, 0, 0, 1);
        tbl[2]  = row(N, 0,         0, 0, 0, 0, 1);
        tbl[3]  = row(N, 0,         0, 0, 0, 0, 1);
        tbl[4]  = row(N, 0,         0, 0, 1, 0, 1);
        tbl[5]  = row(S, 32'h40,    D, 1, 0, 0, 0);
        tbl[6]  = row(L, 32'h44,    0, 2, 0, 0, 1);
        tbl[7]  = row(N, 0,         0, 0, 0, 0, 2);
        tbl[8]  = row(N, 0,         0, 0, 0, 0, 2);
        tbl[9]  = row(N, 0,         0, 0, 0, 0, 2);
        tbl[10] = row(N, 0,         0, 0, 2, D, 1);
        tbl[11] = row(L, 32'h40,    0, 1, 0, 0, 0);
        tbl[12] = row(S, 32'h40,    1, 2, 0, 0, 1);
        tbl[13] = row(N, 0,         0, 0, 0, 0, 2);
        tbl[14] = row(N, 0,         0, 0, 0, 0, 2);
        tbl[15] = row(N, 0,         0, 0, 1, D, 2);
        tbl[16] = row(N, 0,         0, 0, 0, 0, 1);
        tbl[17] = row(L, 32'h40,    0, 1, 0, 0, 0);
        tbl[18] = row(L, 32'h0,     0, 2, 0, 0, 1);
        tbl[19] = row(L, 32'h10000, 0, 3, 0, 0, 2);
        tbl[20] = row(N, 0,         0, 0, 0, 0, 3);
        tbl[21] = row(N, 0,         0, 0, 1, 1, 3);
        tbl[22] = row(N, 0,         0, 0, 2, 0, 2);
        tbl[23] = row(N, 0,         0, 0, 3, 0, 1);
        tbl[24] = row(S, 32'h10000, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 0, 0);
        tbl[25] = row(L, 32'h0,     0, 2, 0, 0, 1);
        tbl[26] = row(N, 0,         0, 0, 0, 0, 2);
        tbl[27] = row(N, 0,         0, 0, 0, 0, 2);
        tbl[28] = row(N, 0,         0, 0, 0, 0, 2);
        tbl[29] = row(N, 0,         0, 0, 2, 0, 1);
        tbl[30] = row(N, 0,         0, 0, 0, 0, 0);

        // Reset state, with a load presented so tag forcing is exercised.
        cmd = L; addr = 32'h8; cmd2 = L;
        repeat (3) @(negedge clock);
        #1;
        check("reset_ttag", 64'(ttag), 64'd0);
        check("reset_dtag", 64'(dtag), 64'd0);
        check("reset_data", rdat, 64'd0);
        check("reset_cnt",  64'(cnt),  64'd0);
        check("reset_ttag2", 64'(ttag2), 64'd0);
        cmd = N; cmd2 = N;
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 31; i++) begin
            drive(tbl[i].cmd, tbl[i].addr, tbl[i].wdat);
            check($sformatf("row%0d_ttag", i), 64'(ttag), 64'(tbl[i].ttag));
            check($sformatf("row%0d_dtag", i), 64'(dtag), 64'(tbl[i].dtag));
            check($sformatf("row%0d_cnt", i),  64'(cnt),  64'(tbl[i].cnt));
            if (tbl[i].dtag != 4'd0)
                check($sformatf("row%0d_data", i), rdat, tbl[i].rdat);
        end

        // Reset mid-flight: in-flight load discarded, next load gets tag 1.
        drive(L, 32'h40, 0);
        check("rst_seq_accept", 64'(ttag), 64'd1);
        drive(N, 0, 0);
        @(negedge clock);
        reset = 1'b1; cmd = L;
        #1;
        check("rst_seq_ttag_forced", 64'(ttag), 64'd0);
        check("rst_seq_dtag_cleared", 64'(dtag), 64'd0);
        check("rst_seq_cnt_cleared", 64'(cnt), 64'd0);
        @(negedge clock);
        reset = 1'b0; cmd = N;
        #1;
        for (int i = 0; i < 6; i++) begin
            drive(N, 0, 0);
            check($sformatf("rst_seq_nopulse%0d", i), 64'(dtag), 64'd0);
        end
        drive(L, 32'h40, 0);
        check("rst_seq_next_tag", 64'(ttag), 64'd1);
        drive(N, 0, 0);

        // Two-tag instance: exhaustion, rejection without pulse, reuse timing.
        drive2(L);
        check("t2_c0_ttag", 64'(ttag2), 64'd1);
        drive2(L);
        check("t2_c1_ttag", 64'(ttag2), 64'd2);
        drive2(L);
        check("t2_c2_reject", 64'(ttag2), 64'd0);
        drive2(N);
        check("t2_c3_cnt", 64'(cnt2), 64'd2);
        drive2(L);
        check("t2_c4_reject", 64'(ttag2), 64'd0);
        check("t2_c4_dtag", 64'(dtag2), 64'd1);
        drive2(L);
        check("t2_c5_ttag", 64'(ttag2), 64'd1);
        check("t2_c5_dtag", 64'(dtag2), 64'd2);
        drive2(N);
        check("t2_c6_nopulse", 64'(dtag2), 64'd0);
        drive2(N);
        check("t2_c7_nopulse", 64'(dtag2), 64'd0);
        drive2(N);
        check("t2_c8_nopulse", 64'(dtag2), 64'd0);
        drive2(N);
        check("t2_c9_dtag", 64'(dtag2), 64'd1);
        drive2(N);
        check("t2_c10_cnt", 64'(cnt2), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
